regfile_mrd: RTL and testbench
==============================

Name: regfile_mrd

Overview:
- Parametrised register file for the pipelined CPU datapath: DEPTH registers of WIDTH bits, one synchronous write port, NUM_RD independent read ports.
- Generalises the fixed 32:1, 1-bit read selection to arbitrary depth, width and port count.
- Adds a hardwired-zero register, an optional write-to-read bypass and an optional registered-read mode.
- Sits in the ID stage, feeding the ID/EX pipeline register; the WB stage drives the write port.

Parameters:
- WIDTH, 64, bits per register.
- DEPTH, 32, number of registers; power of two, at least 2.
- NUM_RD, 2, number of read ports, at least 1.
- ZERO_REG, DEPTH-1, index of the hardwired-zero register; -1 disables the feature.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns wr_data; 0 = it returns the old contents.
- READ_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.
- Derived: AW = log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write enable.
- wr_addr  input  AW  write register index.
- wr_data  input  WIDTH  write data.
- rd_addr  input  NUM_RD*AW  packed read indices; port p uses bits [p*AW +: AW].
- rd_en  input  NUM_RD  per-port output-register load enable; ignored when READ_REG=0.
- rd_data  output  NUM_RD*WIDTH  packed read data; port p uses bits [p*WIDTH +: WIDTH].

Behaviour:
- Interface fixed: single clock clk; reset is asynchronous and active-high.
- Reset:
  - Asserting reset immediately clears every register to 0, regardless of clk.
  - When READ_REG=1, it also clears every rd_data output register to 0.
  - While reset is high, writes and output-register loads are blocked.
  - A write presented on the edge where reset is still high is lost.
  - Reset mid-operation discards any in-flight registered read.
- Write:
  - On a rising edge with wr_en=1 and wr_addr != ZERO_REG, mem[wr_addr] <= wr_data.
  - Writes to ZERO_REG are silently dropped.
  - wr_addr is always below DEPTH, so no out-of-range case exists.
- Read value for port p (call it rv_p):
  - If rd_addr_p == ZERO_REG: rv_p = 0 always, including when a write to ZERO_REG is in flight.
  - Else if BYPASS=1, wr_en=1 and wr_addr == rd_addr_p: rv_p = wr_data.
  - Otherwise: rv_p = mem[rd_addr_p].
- READ_REG=0:
  - rd_data_p = rv_p combinationally, zero-cycle latency.
  - During reset, output is 0 for all addresses because mem is 0 and the bypass is gated by reset.
- READ_REG=1:
  - On a rising edge with rd_en[p]=1, rd_data_p <= rv_p; with rd_en[p]=0 it holds its value.
  - Latency is 1 cycle from address to data.
  - With BYPASS=0 and a same-address write on the same edge, the captured value is the pre-write contents.
- Simultaneous events:
  - All ports may read the same address in one cycle; each gets an identical result.
  - A read and a write to the same address follow the bypass rule above.
  - Ports are fully independent; there are no arbitration or stall outputs.
- Arithmetic: none; data passes bit-exact, with no sign or zero extension.

Decomposition:
- Package regfile_pkg holds:
  - function clog2_f(depth) for AW;
  - localparam DEF_WIDTH = 64, DEF_DEPTH = 32, DEF_ZERO_REG = 31;
  - typedef for packed address/data slices used by the ID stage.
- Sub-module read_mux_n: a parametrised DEPTH:1, WIDTH-bit selector built recursively from 2:1 stages.
  - One instance per read port, generated NUM_RD times.
  - The bypass and zero-forcing logic wraps the mux output inside regfile_mrd.

Test Plan:
1. Reset then read: assert reset with no clk edge, then read all 32 addresses on both ports -> rd_data = 0 for every address, with reset and immediately after release.
2. Write/read sweep (READ_REG=0, BYPASS=0): write mem[i] = 64'hA5A5_0000_0000_0000 | i for i = 0..30, then read i on port 0 and 30-i on port 1 -> exact values returned the same cycle.
3. Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to address 31, then read 31 on both ports -> 0. Same-cycle write+read of 31 with BYPASS=1 -> 0.
4. Bypass: mem[5] = 64'h1111; wr_en=1, wr_addr=5, wr_data=64'h2222 with rd_addr0=5.
   - BYPASS=1: rd_data0 = 64'h2222 pre-edge.
   - BYPASS=0: rd_data0 = 64'h1111 pre-edge, 64'h2222 post-edge.
5. Registered read (READ_REG=1): rd_addr0=7 (mem[7] = 64'h77), rd_en=2'b01 -> rd_data0 = 64'h77 one edge later. rd_data1 holds its prior value. With rd_en[0]=0 and rd_addr0 changed, rd_data0 stays 64'h77.
6. Reset mid-operation (READ_REG=1, NUM_RD=3, WIDTH=16): fill registers, pulse reset asynchronously between edges -> all rd_data drop to 0 without a clk edge. A wr_en on the edge where reset is still high is not stored, so the next read returns 0.

Source files
------------

// File: rtl/regfile_mrd_pkg.sv
// Shared definitions for the ID-stage register file: default geometry,
// address-width helper and the slice types the ID stage uses.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH    = 64;
    localparam int unsigned DEF_DEPTH    = 32;
    localparam int          DEF_ZERO_REG = 31;

    // Number of index bits needed to address depth entries.
    function automatic int unsigned clog2_f(input int unsigned depth);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = depth - 1;
        while (v != 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_AW = clog2_f(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]    reg_addr_t;
    typedef logic [DEF_WIDTH-1:0] reg_data_t;

    // Write-back request as carried from WB to the write port.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

endpackage

// File: rtl/regfile_mrd_read_mux_n.sv
// DEPTH:1 selector of WIDTH-bit words, built as log2(DEPTH) levels of 2:1 muxes.
module read_mux_n
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = clog2_f(DEPTH)
) (
    input  logic [WIDTH-1:0] i_data [DEPTH],
    input  logic [AW-1:0]    i_sel,
    output logic [WIDTH-1:0] o_data_c
);

    logic [WIDTH-1:0] w_lvl [DEPTH];

    // Each level halves the candidate set using one select bit, LSB first.
    always_comb begin
        w_lvl = i_data;
        for (int k = 0; k < int'(AW); k++) begin
            for (int j = 0; j < (int'(DEPTH) >> (k + 1)); j++) begin
                w_lvl[j] = i_sel[k] ? w_lvl[2*j+1] : w_lvl[2*j];
            end
        end
    end

    assign o_data_c = w_lvl[0];

endmodule

// File: rtl/regfile_mrd.sv
// Multi-read-port register file: one synchronous write port, NUM_RD read
// ports with optional hardwired-zero register, write bypass and output regs.
module regfile_mrd
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEF_WIDTH,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int          ZERO_REG = int'(DEPTH) - 1,
    parameter  int unsigned BYPASS   = 1,
    parameter  int unsigned READ_REG = 0,
    localparam int unsigned AW       = clog2_f(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    input  logic [NUM_RD-1:0]       rd_en,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    localparam bit            HAS_ZERO  = (ZERO_REG >= 0);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam bit            USE_BYP   = (BYPASS != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;

    assign w_wr_ok = wr_en && !(HAS_ZERO && (wr_addr == ZERO_ADDR));

    // Storage array: cleared asynchronously, written from WB; zero register never stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_port
        logic [AW-1:0]    w_addr;
        logic [WIDTH-1:0] w_mux;
        logic [WIDTH-1:0] w_rv;

        assign w_addr = rd_addr[p*AW +: AW];

        read_mux_n #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_mux (
            .i_data   (r_mem),
            .i_sel    (w_addr),
            .o_data_c (w_mux)
        );

        // Zero register wins over bypass; bypass is suppressed while in reset.
        always_comb begin
            w_rv = w_mux;
            if (HAS_ZERO && (w_addr == ZERO_ADDR)) begin
                w_rv = '0;
            end else if (USE_BYP && wr_en && !reset && (wr_addr == w_addr)) begin
                w_rv = wr_data;
            end
        end

        if (READ_REG != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;

            // Output register loads the resolved read value when enabled.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (rd_en[p]) begin
                    r_q <= w_rv;
                end
            end

            assign rd_data[p*WIDTH +: WIDTH] = r_q;
        end else begin : g_comb
            logic w_unused_en;

            assign w_unused_en               = rd_en[p];
            assign rd_data[p*WIDTH +: WIDTH] = w_rv;
        end
    end

endmodule

// File: tb/tb_regfile_mrd.sv
// Directed bench for regfile_mrd: four configurations share the write bus.
module tb_regfile_mrd;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [9:0]   rd_addr;
    logic [1:0]   rd_en;
    logic [14:0]  rd_addr3;
    logic [2:0]   rd_en3;
    logic [127:0] rd0, rd1, rd2;
    logic [47:0]  rd3;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] TAG = 64'hA5A5_0000_0000_0000;

    always #5 clk = ~clk;

    // u0: comb read, no bypass
    regfile_mrd #(.BYPASS(0), .READ_REG(0)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd0));
    // u1: comb read, bypass
    regfile_mrd #(.BYPASS(1), .READ_REG(0)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd1));
    // u2: registered read
    regfile_mrd #(.BYPASS(1), .READ_REG(1)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd2));
    // u3: registered read, 3 ports, 16-bit
    regfile_mrd #(.WIDTH(16), .NUM_RD(3), .READ_REG(1)) u3 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[15:0]),
        .rd_addr(rd_addr3), .rd_en(rd_en3), .rd_data(rd3));

    function automatic logic [63:0] s64(input logic [127:0] v, input int p);
        return v[p*64 +: 64];
    endfunction

    function automatic logic [63:0] s16(input logic [47:0] v, input int p);
        return 64'(v[p*16 +: 16]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; rd_en = '0; rd_addr3 = '0; rd_en3 = '0;

        // 1. reset with no clock edge, then sweep reads during and after reset
        #2 reset = 1'b1;
        #1;
        chk("rst_noedge_u0p0", s64(rd0, 0), 64'h0);
        chk("rst_noedge_u2p0", s64(rd2, 0), 64'h0);
        chk("rst_noedge_u2p1", s64(rd2, 1), 64'h0);
        for (int p = 0; p < 3; p++) chk($sformatf("rst_noedge_u3p%0d", p), s16(rd3, p), 64'h0);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            chk($sformatf("rst_in_a%0d_p0", a), s64(rd0, 0), 64'h0);
            chk($sformatf("rst_in_a%0d_p1", a), s64(rd0, 1), 64'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            chk($sformatf("rst_out_a%0d_p0", a), s64(rd0, 0), 64'h0);
            chk($sformatf("rst_out_a%0d_p1", a), s64(rd0, 1), 64'h0);
        end

        // 2. write sweep, read back i on port 0 and 30-i on port 1
        for (int i = 0; i < 31; i++) wr(5'(i), TAG | 64'(i));
        for (int i = 0; i < 31; i++) begin
            rd_addr = {5'(30 - i), 5'(i)};
            #1;
            chk($sformatf("sweep_a%0d_p0", i), s64(rd0, 0), TAG | 64'(i));
            chk($sformatf("sweep_a%0d_p1", 30 - i), s64(rd0, 1), TAG | 64'(30 - i));
        end

        // 3. zero register ignores writes, also under bypass
        wr(5'd31, '1);
        rd_addr = {5'd31, 5'd31};
        #1;
        chk("zero_u0p0", s64(rd0, 0), 64'h0);
        chk("zero_u0p1", s64(rd0, 1), 64'h0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        #1;
        chk("zero_byp_u1p0", s64(rd1, 0), 64'h0);
        chk("zero_byp_u1p1", s64(rd1, 1), 64'h0);
        @(posedge clk);
        #1 wr_en = 1'b0;

        // 4. bypass vs. old contents on a same-address write
        wr(5'd5, 64'h1111);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h2222;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("byp1_pre", s64(rd1, 0), 64'h2222);
        chk("byp0_pre", s64(rd0, 0), 64'h1111);
        @(posedge clk);
        #1;
        chk("byp0_post", s64(rd0, 0), 64'h2222);
        wr_en = 1'b0;

        // 5. registered read: latency, hold on other port, hold when disabled
        wr(5'd7, 64'h77);
        @(negedge clk);
        rd_addr = {5'd3, 5'd9}; rd_en = 2'b10;
        @(posedge clk);
        #1;
        chk("rreg_p1_load", s64(rd2, 1), TAG | 64'h3);
        chk("rreg_p0_idle", s64(rd2, 0), 64'h0);
        @(negedge clk);
        rd_addr = {5'd9, 5'd7}; rd_en = 2'b01;
        #1;
        chk("rreg_p0_pre", s64(rd2, 0), 64'h0);
        @(posedge clk);
        #1;
        chk("rreg_p0_post", s64(rd2, 0), 64'h77);
        chk("rreg_p1_hold", s64(rd2, 1), TAG | 64'h3);
        @(negedge clk);
        rd_en = 2'b00; rd_addr = {5'd9, 5'd3};
        @(posedge clk);
        #1;
        chk("rreg_p0_hold", s64(rd2, 0), 64'h77);

        // 6. async reset between edges on the 3-port 16-bit instance
        @(negedge clk);
        rd_addr3 = {5'd10, 5'd20, 5'd7}; rd_en3 = 3'b111;
        @(posedge clk);
        #1;
        chk("mid_u3p0", s16(rd3, 0), 64'h0077);
        chk("mid_u3p1", s16(rd3, 1), 64'h0014);
        chk("mid_u3p2", s16(rd3, 2), 64'h000A);
        #1 reset = 1'b1;
        #1;
        for (int p = 0; p < 3; p++) chk($sformatf("mid_rst_u3p%0d", p), s16(rd3, p), 64'h0);
        chk("mid_rst_u2p0", s64(rd2, 0), 64'h0);
        chk("mid_rst_u2p1", s64(rd2, 1), 64'h0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hBEEF;
        rd_addr = {5'd12, 5'd12};
        #1;
        chk("rst_byp_gated_u1", s64(rd1, 0), 64'h0);
        chk("rst_read_u0", s64(rd0, 1), 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        rd_addr3 = {5'd12, 5'd12, 5'd12}; rd_en3 = 3'b001;
        #1;
        chk("lost_wr_u0", s64(rd0, 0), 64'h0);
        @(posedge clk);
        #1;
        chk("lost_wr_u3p0", s16(rd3, 0), 64'h0);
        chk("lost_wr_u3p1", s16(rd3, 1), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
